// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
//   arb_state_t : transaction sequencer states
//   grant_t     : which requester owns the current/last transaction
//   ARB_CNT_W   : width of the WAIT-phase timeout counter
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  localparam int ARB_CNT_W = 8;

endpackage

// File: rtl/mem_watchdog.sv
// WAIT-phase timeout counter.
//   clk, rst_n : clock, synchronous active-low reset
//   clr_i      : zero the counter (has priority over en_i)
//   en_i       : count one WAIT cycle without completion
//   expired_o  : the next counted cycle reaches TIMEOUT
module mem_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [ARB_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Flag one count early so the arbiter leaves WAIT on the same edge the
  // count would reach TIMEOUT, giving exactly TIMEOUT WAIT cycles.
  assign expired_o = (cnt_q == ARB_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between the instruction-fetch
// port (read-only) and the data port (read/write). Each access is a single
// strobe followed by a wait for mem_done, bounded by TIMEOUT.
//   clk, rst_n                     : clock, synchronous active-low reset
//   i_addr/i_rstrobe               : fetch request (level, held until i_done)
//   i_rdata/i_done/i_err           : fetch response (one-cycle pulse)
//   d_addr/d_wdata/d_wmask         : data request payload
//   d_wstrobe/d_rstrobe            : data write/read request (level)
//   d_rdata/d_done/d_err           : data response (one-cycle pulse)
//   mem_addr/mem_wdata/mem_wmask   : downstream payload, held per transaction
//   mem_wstrobe/mem_rstrobe        : downstream one-cycle strobes
//   mem_rdata/mem_done             : downstream completion
//   busy                           : arbiter not in IDLE
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_addr,
  input  logic        i_rstrobe,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        i_err,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  input  logic        d_wstrobe,
  input  logic        d_rstrobe,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_wstrobe,
  output logic        mem_rstrobe,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done,
  output logic        busy
);

  arb_state_t  state_q, state_d;
  grant_t      grant_q, grant_d, last_grant_q, last_grant_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic        mem_rstrobe_q, mem_rstrobe_d, mem_wstrobe_q, mem_wstrobe_d;
  logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic        i_done_q, i_done_d, i_err_q, i_err_d;
  logic        d_done_q, d_done_d, d_err_q, d_err_d;
  logic        busy_q, busy_d;

  logic        i_req, d_req, pick_d;
  logic        wd_clr, wd_en, wd_expired;

  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  assign i_req = i_rstrobe;
  assign d_req = d_rstrobe | d_wstrobe;
  // Lone requester wins; on contention the port not granted last wins.
  assign pick_d = d_req && (!i_req || (last_grant_q == GRANT_I));

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wmask_d   = mem_wmask_q;
    mem_rstrobe_d = 1'b0;
    mem_wstrobe_d = 1'b0;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    i_done_d      = 1'b0;
    i_err_d       = 1'b0;
    d_done_d      = 1'b0;
    d_err_d       = 1'b0;
    wd_clr        = 1'b0;
    wd_en         = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d = ISSUE;
          // Strobe registers are loaded here so they are high during ISSUE.
          if (pick_d) begin
            grant_d       = GRANT_D;
            mem_addr_d    = d_addr;
            mem_wdata_d   = d_wdata;
            mem_wmask_d   = d_wmask;
            mem_rstrobe_d = d_rstrobe;
            mem_wstrobe_d = d_wstrobe;
          end else begin
            grant_d       = GRANT_I;
            mem_addr_d    = i_addr;
            mem_wdata_d   = '0;
            mem_wmask_d   = '0;
            mem_rstrobe_d = 1'b1;
            mem_wstrobe_d = 1'b0;
          end
          last_grant_d = grant_d;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        wd_clr  = 1'b1;
      end
      WAIT: begin
        if (mem_done || wd_expired) begin
          state_d = RESP;
          if (grant_q == GRANT_D) begin
            d_done_d  = 1'b1;
            d_err_d   = !mem_done;
            d_rdata_d = mem_done ? mem_rdata : '0;
          end else begin
            i_done_d  = 1'b1;
            i_err_d   = !mem_done;
            i_rdata_d = mem_done ? mem_rdata : '0;
          end
        end else begin
          wd_en = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= GRANT_I;
      last_grant_q  <= GRANT_I;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wmask_q   <= '0;
      mem_rstrobe_q <= 1'b0;
      mem_wstrobe_q <= 1'b0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      i_done_q      <= 1'b0;
      i_err_q       <= 1'b0;
      d_done_q      <= 1'b0;
      d_err_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wmask_q   <= mem_wmask_d;
      mem_rstrobe_q <= mem_rstrobe_d;
      mem_wstrobe_q <= mem_wstrobe_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
      i_done_q      <= i_done_d;
      i_err_q       <= i_err_d;
      d_done_q      <= d_done_d;
      d_err_q       <= d_err_d;
      busy_q        <= busy_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wmask   = mem_wmask_q;
  assign mem_rstrobe = mem_rstrobe_q;
  assign mem_wstrobe = mem_wstrobe_q;
  assign i_rdata     = i_rdata_q;
  assign i_done      = i_done_q;
  assign i_err       = i_err_q;
  assign d_rdata     = d_rdata_q;
  assign d_done      = d_done_q;
  assign d_err       = d_err_q;
  assign busy        = busy_q;

endmodule
